// File: rtl/emu_time_pkg.sv
// Shared types and default widths for the emulation time manager.
// DT_WIDTH may be overridden at compile time through the DT_WIDTH macro.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

package emu_time_pkg;

   localparam int unsigned DT_WIDTH_DEFAULT   = `DT_WIDTH;
   localparam int unsigned TIME_WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      STOP      = 2'd1,
      RUN_UNTIL = 2'd2,
      SLEEP_FOR = 2'd3
   } emu_ctrl_mode_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_UNTIL  = 2'd2,
      ST_HALTED = 2'd3
   } emu_tm_state_t;

   function automatic logic is_halted_state(input emu_tm_state_t s);
      return (s == ST_HOLD) || (s == ST_HALTED);
   endfunction

endpackage

// File: rtl/emu_dt_min_tree.sv
// Combinational balanced min-reduction over N_IN packed unsigned values.
// Pairs are reduced level by level; an unpaired value passes to the next level.
module emu_dt_min_tree #(
   parameter int unsigned N_IN  = 2,
   parameter int unsigned WIDTH = 16
) (
   input  logic [N_IN*WIDTH-1:0] in_flat,
   output logic [WIDTH-1:0]      min_out
);

   localparam int unsigned LEVELS = (N_IN > 1) ? $clog2(N_IN) : 1;

   logic [WIDTH-1:0] work [N_IN];

   always_comb begin
      for (int unsigned i = 0; i < N_IN; i++) begin
         work[i] = in_flat[i*WIDTH +: WIDTH];
      end
      // At each level, slot i absorbs slot i+stride when that partner exists.
      for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
         for (int unsigned i = 0; i < N_IN; i++) begin
            if (((i % (2 << lvl)) == 0) && ((i + (1 << lvl)) < N_IN)) begin
               if (work[i + (1 << lvl)] < work[i]) begin
                  work[i] = work[i + (1 << lvl)];
               end
            end
         end
      end
      min_out = work[0];
   end

endmodule

// File: rtl/emu_time_manager.sv
// Global emulation time-step arbiter: grants the common dt, tracks absolute
// emulation time and applies host run/stop/run-until/sleep-for control.
module emu_time_manager
   import emu_time_pkg::*;
#(
   parameter int unsigned         N_REQ      = 2,
   parameter int unsigned         DT_WIDTH   = DT_WIDTH_DEFAULT,
   parameter int unsigned         TIME_WIDTH = TIME_WIDTH_DEFAULT,
   parameter logic [DT_WIDTH-1:0] DT_MAX     = '1
) (
   input  logic                      __emu_clk,
   input  logic                      __emu_rst,
   input  logic [N_REQ*DT_WIDTH-1:0] __emu_dt_req,
   input  logic [1:0]                ctrl_mode,
   input  logic [TIME_WIDTH-1:0]     ctrl_data,
   output logic [DT_WIDTH-1:0]       __emu_dt,
   output logic [TIME_WIDTH-1:0]     emu_time,
   output logic                      emu_halted
);

   localparam logic [TIME_WIDTH-1:0] DT_MAX_T = TIME_WIDTH'(DT_MAX);

   emu_tm_state_t  state, next_state;
   emu_ctrl_mode_t mode_q, mode_in;

   logic [TIME_WIDTH-1:0] stop_time, stop_time_next;
   logic [TIME_WIDTH-1:0] emu_time_next;
   logic [TIME_WIDTH-1:0] rem_full;
   logic [DT_WIDTH-1:0]   dt_tree, dt_min, rem_sat, dt_grant;
   logic                  mode_change;

   emu_dt_min_tree #(
      .N_IN  (N_REQ),
      .WIDTH (DT_WIDTH)
   ) u_min_tree (
      .in_flat (__emu_dt_req),
      .min_out (dt_tree)
   );

   assign mode_in     = emu_ctrl_mode_t'(ctrl_mode);
   assign mode_change = (mode_in != mode_q);

   assign dt_min   = (dt_tree > DT_MAX) ? DT_MAX : dt_tree;
   // Remaining distance to stop_time; zero once reached or already in the past.
   assign rem_full = (stop_time > emu_time) ? (stop_time - emu_time) : '0;
   assign rem_sat  = (rem_full > DT_MAX_T) ? DT_MAX : DT_WIDTH'(rem_full);

   // Next-state, next stop time and granted step.
   always_comb begin
      next_state     = state;
      stop_time_next = stop_time;
      dt_grant       = '0;

      case (state)
         ST_RUN:   dt_grant = dt_min;
         ST_UNTIL: dt_grant = (rem_sat < dt_min) ? rem_sat : dt_min;
         default:  dt_grant = '0;
      endcase
      if (__emu_rst) begin
         dt_grant = '0;
      end

      emu_time_next = emu_time + TIME_WIDTH'(dt_grant);

      // A mode change takes priority; the step this cycle still follows the old state.
      if (mode_change) begin
         case (mode_in)
            RUN:  next_state = ST_RUN;
            STOP: next_state = ST_HOLD;
            RUN_UNTIL: begin
               next_state     = ST_UNTIL;
               stop_time_next = ctrl_data;
            end
            SLEEP_FOR: begin
               next_state     = ST_UNTIL;
               stop_time_next = emu_time_next + ctrl_data;
            end
            default: next_state = ST_RUN;
         endcase
      end else if (state == ST_UNTIL) begin
         if ((rem_full == '0) || (emu_time_next == stop_time)) begin
            next_state = ST_HALTED;
         end
      end

      __emu_dt = dt_grant;
   end

   // State, control and time registers.
   always_ff @(posedge __emu_clk) begin
      if (__emu_rst) begin
         state      <= ST_RUN;
         mode_q     <= RUN;
         stop_time  <= '0;
         emu_time   <= '0;
         emu_halted <= 1'b0;
      end else begin
         state      <= next_state;
         mode_q     <= mode_in;
         stop_time  <= stop_time_next;
         emu_time   <= emu_time_next;
         emu_halted <= is_halted_state(next_state);
      end
   end

endmodule

// File: tb/tb_emu_time_manager.sv
// Directed bench for emu_time_manager: step arbitration, run/stop/until/sleep
// control and reset behaviour against hand-computed values.
module tb_emu_time_manager;

   localparam int unsigned N_REQ      = 2;
   localparam int unsigned DT_WIDTH   = 16;
   localparam int unsigned TIME_WIDTH = 64;

   logic                      clk;
   logic                      rst;
   logic [N_REQ*DT_WIDTH-1:0] req;
   logic [1:0]                mode;
   logic [TIME_WIDTH-1:0]     data;
   logic [DT_WIDTH-1:0]       dt;
   logic [TIME_WIDTH-1:0]     etime;
   logic                      halted;

   int n_checks = 0;
   int n_fail   = 0;

   emu_time_manager #(
      .N_REQ      (N_REQ),
      .DT_WIDTH   (DT_WIDTH),
      .TIME_WIDTH (TIME_WIDTH)
   ) dut (
      .__emu_clk    (clk),
      .__emu_rst    (rst),
      .__emu_dt_req (req),
      .ctrl_mode    (mode),
      .ctrl_data    (data),
      .__emu_dt     (dt),
      .emu_time     (etime),
      .emu_halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reqs(input logic [DT_WIDTH-1:0] r0, input logic [DT_WIDTH-1:0] r1);
      req = {r1, r0};
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_val("dt_in_reset", 64'(dt), 64'd0);
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      mode = 2'd0;
      data = '0;

      // Reset state
      set_reqs(16'd5, 16'd3);
      do_reset();
      check_val("rst_time", etime, 64'd0);
      check_val("rst_halted", 64'(halted), 64'd0);

      // 1. RUN with {5,3}
      check_val("t1_dt", 64'(dt), 64'd3);
      step(); check_val("t1_time3", etime, 64'd3);
      step(); check_val("t1_time6", etime, 64'd6);
      step(); check_val("t1_time9", etime, 64'd9);

      // 2. Zero request freezes time, then req0=4
      set_reqs(16'd0, 16'd7);
      check_val("t2_dt0", 64'(dt), 64'd0);
      step(); check_val("t2_frozen", etime, 64'd9);
      set_reqs(16'd4, 16'd7);
      check_val("t2_dt4", 64'(dt), 64'd4);
      step(); check_val("t2_time13", etime, 64'd13);

      // 3. RUN_UNTIL 10 from t=0 with {4,4}
      do_reset();
      set_reqs(16'd4, 16'd4);
      mode = 2'd2; data = 64'd10; #1;
      check_val("t3_dt_a", 64'(dt), 64'd4);
      step(); check_val("t3_time4", etime, 64'd4);
      data = 64'd1000; #1;
      check_val("t3_dt_b", 64'(dt), 64'd4);
      step(); check_val("t3_time8", etime, 64'd8);
      check_val("t3_not_halted", 64'(halted), 64'd0);
      check_val("t3_dt_c", 64'(dt), 64'd2);
      step(); check_val("t3_time10", etime, 64'd10);
      check_val("t3_halted", 64'(halted), 64'd1);
      check_val("t3_dt_d", 64'(dt), 64'd0);
      step(); check_val("t3_time_hold", etime, 64'd10);

      // 4. Back to RUN to reach t=20, then SLEEP_FOR 6 with {10,10}
      set_reqs(16'd10, 16'd10);
      mode = 2'd0; #1;
      check_val("t4_dt_halted", 64'(dt), 64'd0);
      step(); check_val("t4_time10", etime, 64'd10);
      check_val("t4_unhalted", 64'(halted), 64'd0);
      step(); check_val("t4_time20", etime, 64'd20);
      mode = 2'd3; data = 64'd6; #1;
      check_val("t4_dt_change", 64'(dt), 64'd10);
      step(); check_val("t4_time30", etime, 64'd30);
      check_val("t4_dt6", 64'(dt), 64'd6);
      step(); check_val("t4_time36", etime, 64'd36);
      check_val("t4_halted", 64'(halted), 64'd1);
      data = 64'd50; #1;
      check_val("t4_dt_after", 64'(dt), 64'd0);
      step(); check_val("t4_no_rearm", etime, 64'd36);

      // 5. RUN_UNTIL 5 while emu_time=8 (past stop time)
      do_reset();
      set_reqs(16'd8, 16'd8);
      mode = 2'd1; #1;
      step(); check_val("t5_time8", etime, 64'd8);
      check_val("t5_hold", 64'(halted), 64'd1);
      check_val("t5_hold_dt", 64'(dt), 64'd0);
      mode = 2'd2; data = 64'd5; #1;
      step(); check_val("t5_until_time", etime, 64'd8);
      check_val("t5_until_unhalted", 64'(halted), 64'd0);
      check_val("t5_past_dt", 64'(dt), 64'd0);
      step(); check_val("t5_halted", 64'(halted), 64'd1);
      check_val("t5_time_stays", etime, 64'd8);

      // 6. Reset in ST_UNTIL mid-sleep
      set_reqs(16'd4, 16'd4);
      mode = 2'd3; data = 64'd100; #1;
      step(); check_val("t6_sleep_time", etime, 64'd8);
      check_val("t6_sleep_dt", 64'(dt), 64'd4);
      step(); check_val("t6_time12", etime, 64'd12);
      mode = 2'd0;
      do_reset();
      check_val("t6_rst_time", etime, 64'd0);
      check_val("t6_rst_halted", 64'(halted), 64'd0);
      set_reqs(16'd9, 16'd4);
      check_val("t6_dt_min", 64'(dt), 64'd4);
      step(); check_val("t6_time4", etime, 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
